bp_fe_ras_stack: RTL and testbench

Parametrised, multi-entry return address stack (RAS) for the dual/N-wide frontend; it replaces the single-register return-address latch in the fetch PC generator. Each cycle it scans a fetch_width_p-wide bundle, pushes the return address for the first call and pops for the first return, and presents the top-of-stack target to the PC-select mux. It also exports a per-fetch checkpoint so a backend redirect can restore the speculative stack state.

---
 rtl/bp_fe_pkg.sv | 60 ++++++
 rtl/bp_fe_ras_lane_select.sv | 46 ++++
 rtl/bp_fe_ras_stack.sv | 151 +++++++++++++++
 tb/tb_bp_fe_ras_stack.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: shared frontend types for the return address stack.
//
// Contents:
//   - `BP_FE_RAS_CKPT_WIDTH(vaddr_width, ras_els) : checkpoint width in bits
//   - `DECLARE_BP_FE_RAS_CKPT_S(vaddr_width, ras_els) : declares the packed
//     checkpoint struct bp_fe_ras_ckpt_s so branch metadata can embed it
//   - bp_fe_ras_op_e / bp_fe_ras_decode : stack operation for one fetch
//
// Configuration macro: BP_FE_RAS_TOS_REPAIR_EN
//   When defined, the checkpoint also carries the top-of-stack address in its
//   most significant bits, above {count, tos_ptr}.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`ifdef BP_FE_RAS_TOS_REPAIR_EN
`define BP_FE_RAS_CKPT_WIDTH(vaddr_width_mp, ras_els_mp) \
  ($clog2(ras_els_mp) + $clog2((ras_els_mp) + 1) + (vaddr_width_mp))
`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ras_els_mp) \
  typedef struct packed { \
    logic [(vaddr_width_mp)-1:0]         tos_addr; \
    logic [$clog2((ras_els_mp)+1)-1:0]   count; \
    logic [$clog2(ras_els_mp)-1:0]       tos_ptr; \
  } bp_fe_ras_ckpt_s
`else
`define BP_FE_RAS_CKPT_WIDTH(vaddr_width_mp, ras_els_mp) \
  ($clog2(ras_els_mp) + $clog2((ras_els_mp) + 1))
`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ras_els_mp) \
  typedef struct packed { \
    logic [$clog2((ras_els_mp)+1)-1:0]   count; \
    logic [$clog2(ras_els_mp)-1:0]       tos_ptr; \
  } bp_fe_ras_ckpt_s
`endif

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_ras_nop  = 2'd0,
    e_ras_push = 2'd1,
    e_ras_pop  = 2'd2,
    e_ras_swap = 2'd3   // call and return on the same instruction
  } bp_fe_ras_op_e;

  // Stack operation requested by the active lane of a consumed bundle.
  function automatic bp_fe_ras_op_e bp_fe_ras_decode(input logic fetch_v,
                                                     input logic lane_v,
                                                     input logic is_call,
                                                     input logic is_ret);
    bp_fe_ras_op_e op;
    op = e_ras_nop;
    if (fetch_v && lane_v) begin
      if (is_call && is_ret) op = e_ras_swap;
      else if (is_call)      op = e_ras_push;
      else                   op = e_ras_pop;
    end
    return op;
  endfunction

endpackage

`endif

// File: rtl/bp_fe_ras_lane_select.sv
// bp_fe_ras_lane_select: picks the first control-flow lane of a fetch bundle.
//
// Ports:
//   lane_pc_i  per-lane PC, lane 0 in the LSBs
//   call_v_i   per-lane call flag
//   ret_v_i    per-lane return flag
//   v_o        some lane carries a call or return
//   lane_o     index of the lowest such lane
//   is_call_o  that lane is a call
//   is_ret_o   that lane is a return
//   pc_o       PC of that lane
module bp_fe_ras_lane_select #(
  parameter int fetch_width_p = 2,
  parameter int vaddr_width_p = 39,
  parameter int lane_w_p      = 1
) (
  input  logic [fetch_width_p*vaddr_width_p-1:0] lane_pc_i,
  input  logic [fetch_width_p-1:0]               call_v_i,
  input  logic [fetch_width_p-1:0]               ret_v_i,
  output logic                                   v_o,
  output logic [lane_w_p-1:0]                    lane_o,
  output logic                                   is_call_o,
  output logic                                   is_ret_o,
  output logic [vaddr_width_p-1:0]               pc_o
);

  // Scan from the top lane down so the lowest matching lane is the last
  // assignment and therefore wins.
  always_comb begin
    v_o       = 1'b0;
    lane_o    = '0;
    is_call_o = 1'b0;
    is_ret_o  = 1'b0;
    pc_o      = '0;
    for (int i = fetch_width_p - 1; i >= 0; i--) begin
      if (call_v_i[i] || ret_v_i[i]) begin
        v_o       = 1'b1;
        lane_o    = lane_w_p'(i);
        is_call_o = call_v_i[i];
        is_ret_o  = ret_v_i[i];
        pc_o      = lane_pc_i[i*vaddr_width_p +: vaddr_width_p];
      end
    end
  end

endmodule

// File: rtl/bp_fe_ras_stack.sv
// bp_fe_ras_stack: circular return address stack for an N-wide frontend.
//
// Each consumed bundle updates the stack from its first call/return lane:
// push the return address on a call, pop on a return, overwrite the top on a
// call+return. A checkpoint of the pre-update state is exported every cycle so
// a backend redirect can restore the speculative stack.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   init_done_o      stack cleared and usable
//   fetch_v_i        bundle consumed this cycle
//   lane_pc_i        per-lane PC, lane 0 in the LSBs
//   call_v_i/ret_v_i per-lane call / return flags
//   tgt_o, tgt_v_o   top-of-stack target and stack-non-empty
//   ckpt_o           {count, tos_ptr} (TOS address above them when repair is on)
//   restore_v_i      restore from restore_ckpt_i; beats same-cycle push/pop
//
// Configuration macro: BP_FE_RAS_TOS_REPAIR_EN rewrites entry[restored ptr]
// with the checkpointed top-of-stack address on restore.
module bp_fe_ras_stack
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = 8,
  parameter int fetch_width_p = 2,
  parameter int instr_bytes_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  output logic                                   init_done_o,
  input  logic                                   fetch_v_i,
  input  logic [fetch_width_p*vaddr_width_p-1:0] lane_pc_i,
  input  logic [fetch_width_p-1:0]               call_v_i,
  input  logic [fetch_width_p-1:0]               ret_v_i,
  output logic [vaddr_width_p-1:0]               tgt_o,
  output logic                                   tgt_v_o,
  output logic [`BP_FE_RAS_CKPT_WIDTH(vaddr_width_p, ras_els_p)-1:0] ckpt_o,
  input  logic                                   restore_v_i,
  input  logic [`BP_FE_RAS_CKPT_WIDTH(vaddr_width_p, ras_els_p)-1:0] restore_ckpt_i
);

  localparam int ptr_w  = $clog2(ras_els_p);
  localparam int cnt_w  = $clog2(ras_els_p + 1);
  localparam int lane_w = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;

  `DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_p, ras_els_p);

  logic [vaddr_width_p-1:0] entry_q [ras_els_p];
  logic [vaddr_width_p-1:0] entry_d [ras_els_p];
  logic [ptr_w-1:0]         tos_ptr_q, tos_ptr_d;
  logic [cnt_w-1:0]         count_q, count_d;
  logic                     init_done_q, init_done_d;

  logic                     sel_v, sel_call, sel_ret;
  logic [lane_w-1:0]        sel_lane;
  logic [vaddr_width_p-1:0] sel_pc, ret_addr;
  logic [ptr_w-1:0]         push_ptr, pop_ptr;
  bp_fe_ras_op_e            op;
  bp_fe_ras_ckpt_s          ckpt, restore_ckpt;

  bp_fe_ras_lane_select #(
    .fetch_width_p(fetch_width_p),
    .vaddr_width_p(vaddr_width_p),
    .lane_w_p     (lane_w)
  ) lane_select (
    .lane_pc_i(lane_pc_i),
    .call_v_i (call_v_i),
    .ret_v_i  (ret_v_i),
    .v_o      (sel_v),
    .lane_o   (sel_lane),
    .is_call_o(sel_call),
    .is_ret_o (sel_ret),
    .pc_o     (sel_pc)
  );

  // The stack update only needs the selected lane's flags and PC; the index
  // itself is informational.
  logic unused_sel_lane;
  assign unused_sel_lane = ^sel_lane;

  assign ret_addr     = sel_pc + vaddr_width_p'(instr_bytes_p);
  // Power-of-two depth: pointer arithmetic wraps naturally.
  assign push_ptr     = tos_ptr_q + 1'b1;
  assign pop_ptr      = tos_ptr_q - 1'b1;
  assign op           = bp_fe_ras_decode(fetch_v_i, sel_v, sel_call, sel_ret);
  assign restore_ckpt = bp_fe_ras_ckpt_s'(restore_ckpt_i);

  always_comb begin
    entry_d     = entry_q;
    tos_ptr_d   = tos_ptr_q;
    count_d     = count_q;
    init_done_d = 1'b1;
    if (restore_v_i) begin
      tos_ptr_d = restore_ckpt.tos_ptr;
      count_d   = restore_ckpt.count;
`ifdef BP_FE_RAS_TOS_REPAIR_EN
      entry_d[restore_ckpt.tos_ptr] = restore_ckpt.tos_addr;
`endif
    end else begin
      case (op)
        e_ras_push: begin
          // Full stack: the oldest entry is overwritten and count saturates.
          entry_d[push_ptr] = ret_addr;
          tos_ptr_d         = push_ptr;
          if (count_q != cnt_w'(ras_els_p)) count_d = count_q + 1'b1;
        end
        e_ras_pop: begin
          // Underflow is silently ignored.
          if (count_q != '0) begin
            tos_ptr_d = pop_ptr;
            count_d   = count_q - 1'b1;
          end
        end
        e_ras_swap: begin
          entry_d[tos_ptr_q] = ret_addr;
          if (count_q == '0) count_d = cnt_w'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ras_els_p; i++) entry_q[i] <= '0;
      tos_ptr_q   <= '0;
      count_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      tos_ptr_q   <= tos_ptr_d;
      count_q     <= count_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    ckpt         = '0;
    ckpt.count   = count_q;
    ckpt.tos_ptr = tos_ptr_q;
`ifdef BP_FE_RAS_TOS_REPAIR_EN
    ckpt.tos_addr = entry_q[tos_ptr_q];
`endif
  end

  assign ckpt_o      = ckpt;
  assign tgt_o       = entry_q[tos_ptr_q];
  assign tgt_v_o     = (count_q != '0);
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_bp_fe_ras_stack.sv
module tb_bp_fe_ras_stack;
  localparam int VW  = 39;
  localparam int RAS = 8;
  localparam int FW  = 2;
  localparam int IB  = 4;
  localparam int PW  = 3;
  localparam int CW  = 4;
`ifdef BP_FE_RAS_TOS_REPAIR_EN
  localparam int CKW = PW + CW + VW;
`else
  localparam int CKW = PW + CW;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic           init_done_o;
  logic           fetch_v_i = 1'b0;
  logic [FW*VW-1:0] lane_pc_i = '0;
  logic [FW-1:0]  call_v_i = '0;
  logic [FW-1:0]  ret_v_i = '0;
  logic [VW-1:0]  tgt_o;
  logic           tgt_v_o;
  logic [CKW-1:0] ckpt_o;
  logic           restore_v_i = 1'b0;
  logic [CKW-1:0] restore_ckpt_i = '0;

  always #5 clk = ~clk;

  bp_fe_ras_stack #(
    .vaddr_width_p(VW), .ras_els_p(RAS), .fetch_width_p(FW), .instr_bytes_p(IB)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
    .fetch_v_i(fetch_v_i), .lane_pc_i(lane_pc_i),
    .call_v_i(call_v_i), .ret_v_i(ret_v_i),
    .tgt_o(tgt_o), .tgt_v_o(tgt_v_o), .ckpt_o(ckpt_o),
    .restore_v_i(restore_v_i), .restore_ckpt_i(restore_ckpt_i)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [VW-1:0] m_ent [RAS];
  int m_ptr;
  int m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < RAS; i++) m_ent[i] = '0;
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic logic [CKW-1:0] m_ckpt();
    logic [CKW-1:0] v;
    v = '0;
    v[PW-1:0]  = PW'(m_ptr);
    v[PW+:CW]  = CW'(m_cnt);
`ifdef BP_FE_RAS_TOS_REPAIR_EN
    v[PW+CW+:VW] = m_ent[m_ptr];
`endif
    return v;
  endfunction

  function automatic void model_step(input bit fv, input logic [FW*VW-1:0] pcs,
                                     input logic [FW-1:0] c, input logic [FW-1:0] r,
                                     input bit rv, input logic [CKW-1:0] rc);
    int act;
    logic [VW-1:0] ra;
    if (rv) begin
      m_ptr = int'(rc[PW-1:0]);
      m_cnt = int'(rc[PW+:CW]);
`ifdef BP_FE_RAS_TOS_REPAIR_EN
      m_ent[m_ptr] = rc[PW+CW+:VW];
`endif
      return;
    end
    if (!fv) return;
    act = -1;
    for (int l = FW - 1; l >= 0; l--) if (c[l] || r[l]) act = l;
    if (act < 0) return;
    ra = pcs[act*VW +: VW] + VW'(IB);
    if (c[act] && r[act]) begin
      m_ent[m_ptr] = ra;
      if (m_cnt == 0) m_cnt = 1;
    end else if (c[act]) begin
      m_ptr = (m_ptr + 1) % RAS;
      m_ent[m_ptr] = ra;
      if (m_cnt < RAS) m_cnt = m_cnt + 1;
    end else if (m_cnt > 0) begin
      m_ptr = (m_ptr + RAS - 1) % RAS;
      m_cnt = m_cnt - 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit fv, input logic [VW-1:0] pc0, input logic [VW-1:0] pc1,
                       input logic [FW-1:0] c, input logic [FW-1:0] r,
                       input bit rv, input logic [CKW-1:0] rc);
    fetch_v_i      = fv;
    lane_pc_i      = {pc1, pc0};
    call_v_i       = c;
    ret_v_i        = r;
    restore_v_i    = rv;
    restore_ckpt_i = rc;
    if (reset_i) model_reset();
    else model_step(fv, {pc1, pc0}, c, r, rv, rc);
    @(posedge clk);
    #1;
    fetch_v_i   = 1'b0;
    call_v_i    = '0;
    ret_v_i     = '0;
    restore_v_i = 1'b0;
  endtask

  task automatic call0(input logic [VW-1:0] pc);
    drive(1'b1, pc, '0, 2'b01, 2'b00, 1'b0, '0);
  endtask

  task automatic ret0();
    drive(1'b1, '0, '0, 2'b00, 2'b01, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
    reset_i = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    drive(1'b1, 39'h1000, '0, 2'b01, 2'b00, 1'b0, '0);
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
    checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL reset_init: got %b want 0", init_done_o); end
    checks++; if (tgt_o !== '0) begin errors++; $display("FAIL reset_tgt: got %h want 0", tgt_o); end
    checks++; if (tgt_v_o !== 1'b0) begin errors++; $display("FAIL reset_tgt_v: got %b want 0", tgt_v_o); end
    checks++; if (ckpt_o !== '0) begin errors++; $display("FAIL reset_ckpt: got %h want 0", ckpt_o); end
    reset_i = 1'b0;
    checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL init_first_cycle: got %b want 0", init_done_o); end
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
    checks++; if (init_done_o !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", init_done_o); end
  endtask

  task automatic test_call_lane0();
    do_reset();
    call0(39'h1000);
    checks++; if (tgt_o !== 39'h1004) begin errors++; $display("FAIL call_tgt: got %h want 1004", tgt_o); end
    checks++; if (tgt_v_o !== 1'b1) begin errors++; $display("FAIL call_tgt_v: got %b want 1", tgt_v_o); end
    checks++; if (ckpt_o[PW+:CW] !== 4'd1) begin errors++; $display("FAIL call_count: got %0d want 1", ckpt_o[PW+:CW]); end
  endtask

  task automatic test_lane_priority();
    do_reset();
    drive(1'b1, 39'h1111, 39'h2008, 2'b10, 2'b00, 1'b0, '0);
    checks++; if (tgt_o !== 39'h200c) begin errors++; $display("FAIL lane1_call: got %h want 200c", tgt_o); end
    drive(1'b1, 39'h4000, 39'h5000, 2'b01, 2'b10, 1'b0, '0);
    checks++; if (tgt_o !== 39'h4004) begin errors++; $display("FAIL lane0_call_wins: got %h want 4004", tgt_o); end
    checks++; if (ckpt_o[PW+:CW] !== 4'd2) begin errors++; $display("FAIL lane0_call_count: got %0d want 2", ckpt_o[PW+:CW]); end
    drive(1'b1, 39'h0, 39'h6000, 2'b10, 2'b01, 1'b0, '0);
    checks++; if (tgt_o !== 39'h200c) begin errors++; $display("FAIL lane0_ret_wins: got %h want 200c", tgt_o); end
    checks++; if (ckpt_o[PW+:CW] !== 4'd1) begin errors++; $display("FAIL lane0_ret_count: got %0d want 1", ckpt_o[PW+:CW]); end
  endtask

  task automatic test_swap();
    do_reset();
    drive(1'b1, 39'h3000, '0, 2'b01, 2'b01, 1'b0, '0);
    checks++; if (tgt_o !== 39'h3004 || tgt_v_o !== 1'b1) begin errors++; $display("FAIL swap_empty: got %h/%b want 3004/1", tgt_o, tgt_v_o); end
    checks++; if (ckpt_o[PW-1:0] !== 3'd0 || ckpt_o[PW+:CW] !== 4'd1) begin errors++; $display("FAIL swap_empty_ptrs: got ptr %0d cnt %0d want 0 1", ckpt_o[PW-1:0], ckpt_o[PW+:CW]); end
    call0(39'h4000);
    drive(1'b1, 39'h5000, '0, 2'b01, 2'b01, 1'b0, '0);
    checks++; if (tgt_o !== 39'h5004 || ckpt_o[PW+:CW] !== 4'd2) begin errors++; $display("FAIL swap_tgt: got %h cnt %0d want 5004 2", tgt_o, ckpt_o[PW+:CW]); end
    ret0();
    checks++; if (tgt_o !== 39'h3004) begin errors++; $display("FAIL swap_then_pop: got %h want 3004", tgt_o); end
  endtask

  task automatic test_overflow();
    logic [CKW-1:0] saved;
    do_reset();
    for (int i = 1; i <= 9; i++) call0(VW'(i * 'h100));
    checks++; if (ckpt_o[PW+:CW] !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", ckpt_o[PW+:CW]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tgt_o !== VW'((9 - i) * 'h100 + 4) || tgt_v_o !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d: got %h/%b want %h/1", i, tgt_o, tgt_v_o, (9 - i) * 'h100 + 4);
      end
      ret0();
    end
    checks++; if (tgt_v_o !== 1'b0 || ckpt_o !== m_ckpt()) begin errors++; $display("FAIL ovf_empty: got %b ckpt %h want 0 ckpt %h", tgt_v_o, ckpt_o, m_ckpt()); end
    saved = m_ckpt();
    ret0();
    checks++; if (tgt_v_o !== 1'b0 || ckpt_o !== saved || tgt_o !== 39'h904) begin errors++; $display("FAIL underflow: got %h/%b ckpt %h want 904/0 ckpt %h", tgt_o, tgt_v_o, ckpt_o, saved); end
  endtask

  task automatic test_restore();
    logic [CKW-1:0] saved;
    do_reset();
    call0(39'h1000); call0(39'h2000); call0(39'h3000);
    saved = m_ckpt();
    call0(39'h7000); call0(39'h8000);
    drive(1'b1, 39'h9000, '0, 2'b01, 2'b00, 1'b1, saved);
    checks++; if (tgt_o !== 39'h3004 || tgt_v_o !== 1'b1) begin errors++; $display("FAIL restore_tgt: got %h/%b want 3004/1", tgt_o, tgt_v_o); end
    checks++; if (ckpt_o !== saved) begin errors++; $display("FAIL restore_ckpt: got %h want %h", ckpt_o, saved); end
    ret0();
    checks++; if (tgt_o !== 39'h2004) begin errors++; $display("FAIL restore_pop: got %h want 2004", tgt_o); end
  endtask

  task automatic test_tos_repair();
    logic [CKW-1:0] saved;
    logic [VW-1:0]  want;
    do_reset();
    call0(39'h1000); call0(39'h2000); call0(39'h3000);
    saved = m_ckpt();
    ret0();
    call0(39'h5000);
    drive(1'b0, '0, '0, '0, '0, 1'b1, saved);
`ifdef BP_FE_RAS_TOS_REPAIR_EN
    want = 39'h3004;
`else
    want = 39'h5004;
`endif
    checks++; if (tgt_o !== want) begin errors++; $display("FAIL tos_repair: got %h want %h", tgt_o, want); end
    checks++; if (ckpt_o[PW+:CW] !== 4'd3) begin errors++; $display("FAIL tos_repair_count: got %0d want 3", ckpt_o[PW+:CW]); end
  endtask

  task automatic test_no_change();
    do_reset();
    ret0();
    drive(1'b0, 39'h1000, '0, 2'b01, 2'b00, 1'b0, '0);
    checks++; if (tgt_o !== '0 || tgt_v_o !== 1'b0 || ckpt_o !== '0) begin errors++; $display("FAIL no_change: got %h/%b ckpt %h want 0/0 ckpt 0", tgt_o, tgt_v_o, ckpt_o); end
  endtask

  task automatic test_reset_mid_push();
    do_reset();
    call0(39'h1000); call0(39'h2000);
    reset_i = 1'b1;
    drive(1'b1, 39'h3000, '0, 2'b01, 2'b00, 1'b1, CKW'(9));
    checks++; if (tgt_o !== '0 || tgt_v_o !== 1'b0 || ckpt_o !== '0 || init_done_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_push: got %h/%b ckpt %h init %b want all 0", tgt_o, tgt_v_o, ckpt_o, init_done_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_random();
    logic [CKW-1:0] hist[$];
    logic [VW-1:0]  p0, p1;
    logic [FW-1:0]  c, r;
    bit             fv, rv;
    logic [CKW-1:0] rc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      p0 = VW'({$urandom, $urandom});
      p1 = VW'({$urandom, $urandom});
      c  = FW'($urandom_range(0, 3));
      r  = ($urandom_range(0, 2) == 0) ? FW'($urandom_range(0, 3)) : '0;
      fv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 11) == 0) && (hist.size() > 0);
      rc = rv ? hist[$urandom_range(0, hist.size() - 1)] : '0;
      hist.push_back(m_ckpt());
      if (hist.size() > 6) void'(hist.pop_front());
      drive(fv, p0, p1, c, r, rv, rc);
      checks++;
      if (tgt_o !== m_ent[m_ptr] || tgt_v_o !== (m_cnt != 0) || ckpt_o !== m_ckpt()) begin
        errors++;
        $display("FAIL random%0d: got %h/%b ckpt %h want %h/%b ckpt %h", n, tgt_o, tgt_v_o, ckpt_o,
                 m_ent[m_ptr], (m_cnt != 0), m_ckpt());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_call_lane0();
    test_lane_priority();
    test_swap();
    test_overflow();
    test_restore();
    test_tos_repair();
    test_no_change();
    test_reset_mid_push();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
